// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the round-robin UART TX arbiter.
// The optional watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 200000;

  // Width of a requester index; never below one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last_grant+1 upward with
// wrap and returns the first asserted request as one-hot plus index.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    // Offset NUM_REQ lands back on last_grant itself, so it has lowest priority.
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = (int'(last_grant_i) + k) % int'(NUM_REQ);
      if (!found && req_i[cand]) begin
        found            = 1'b1;
        grant_oh_o[cand] = 1'b1;
        grant_idx_o      = IDX_W'(cand);
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to build the WAIT_DONE watchdog.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int unsigned IDX_W         = grant_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_start,
  output logic [DATA_W-1:0]         uart_data,
  input  logic                      uart_tx_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [DATA_W-1:0]  req_bytes [NUM_REQ];
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .grant_oh_o   (pick_oh),
    .grant_idx_o  (pick_idx),
    .grant_any_o  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          data_d  = req_bytes[pick_idx];
          grant_d = pick_idx;
          last_d  = pick_idx;
          state_d = START;
        end
      end
      START:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (uart_tx_done || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter is zeroed while in START so it starts fresh on WAIT_DONE entry.
  assign timeout_hit = (state_q == WAIT_DONE) && !uart_tx_done &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | timeout_hit;
    if (state_q == START) begin
      cnt_d = '0;
    end else if (state_q == WAIT_DONE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE) ? pick_oh : '0;
  assign uart_start = (state_q == START);
  assign uart_data  = data_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        uart_start;
  logic [7:0]  uart_data;
  logic        uart_tx_done = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .uart_tx_done (uart_tx_done),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_valid    = '0;
    uart_tx_done = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_oh;
    int         exp_idx;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(uart_start), 0);
    chk("rst_data", 32'(uart_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_ready", 32'(req_ready), 0);

    // Single request from requester 0
    req_data  = 32'h0000_0055;
    req_valid = 4'b0001;
    #1;
    chk("s_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("s_start", 32'(uart_start), 1);
    chk("s_data", 32'(uart_data), 32'h55);
    chk("s_grant", 32'(grant_id), 0);
    chk("s_ready_start", 32'(req_ready), 0);
    tick();
    chk("s_start_drop", 32'(uart_start), 0);
    chk("s_busy_wait", 32'(busy), 1);
    tick();
    tick();
    chk("s_data_hold", 32'(uart_data), 32'h55);
    chk("s_busy_pre_done", 32'(busy), 1);
    pulse_done();
    chk("s_busy_post_done", 32'(busy), 0);

    // Done while idle is ignored
    pulse_done();
    chk("idle_done_busy", 32'(busy), 0);
    chk("idle_done_start", 32'(uart_start), 0);

    // Contention: req0 and req2 together after reset
    do_reset();
    req_data  = 32'h00AA_0055;
    req_valid = 4'b0101;
    #1;
    chk("c_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    chk("c_data0", 32'(uart_data), 32'h55);
    chk("c_grant0", 32'(grant_id), 0);
    chk("c_ready_start", 32'(req_ready), 0);
    tick();
    chk("c_ready_wait", 32'(req_ready), 0);
    tick();
    chk("c_ready_wait2", 32'(req_ready), 0);
    pulse_done();
    chk("c_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("c_start2", 32'(uart_start), 1);
    chk("c_data2", 32'(uart_data), 32'hAA);
    chk("c_grant2", 32'(grant_id), 2);
    tick();
    pulse_done();

    // Fairness: all four held valid, expect 0,1,2,3,0,1,2,3
    do_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      exp_idx = i % 4;
      exp_oh  = 4'b0001 << exp_idx;
      #1;
      chk($sformatf("f%0d_ready", i), 32'(req_ready), 32'(exp_oh));
      tick();
      chk($sformatf("f%0d_grant", i), 32'(grant_id), 32'(exp_idx));
      chk($sformatf("f%0d_data", i), 32'(uart_data), 32'h10 + 32'(exp_idx));
      chk($sformatf("f%0d_start", i), 32'(uart_start), 1);
      tick();
      pulse_done();
    end
    req_valid = 4'b0000;

    // Wrap-around: last grant is 3, only req1 valid
    req_data  = 32'hD300_B100;
    req_valid = 4'b0010;
    #1;
    chk("w_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    chk("w_grant1", 32'(grant_id), 1);
    chk("w_data1", 32'(uart_data), 32'hB1);
    tick();
    pulse_done();
    // From last grant 1, req3 precedes req1
    req_valid = 4'b1010;
    #1;
    chk("w_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0010;
    chk("w_grant3", 32'(grant_id), 3);
    chk("w_data3", 32'(uart_data), 32'hD3);
    tick();
    pulse_done();
    #1;
    chk("w_ready1b", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    chk("w_grant1b", 32'(grant_id), 1);
    tick();
    pulse_done();

    // Reset in the middle of WAIT_DONE
    req_data  = 32'h0077_0000;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    chk("r_start", 32'(uart_start), 1);
    chk("r_grant", 32'(grant_id), 2);
    for (int i = 0; i < 5; i++) tick();
    chk("r_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", 32'(busy), 0);
    chk("r_start0", 32'(uart_start), 0);
    chk("r_grant0", 32'(grant_id), 0);
    chk("r_data0", 32'(uart_data), 0);
    req_data  = 32'h0000_0042;
    req_valid = 4'b0001;
    #1;
    chk("r_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("r_grant_after", 32'(grant_id), 0);
    chk("r_data_after", 32'(uart_data), 32'h42);
    // Done during START is ignored
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    chk("r_done_in_start", 32'(busy), 1);
    tick();
    chk("r_still_wait", 32'(busy), 1);
    pulse_done();
    chk("r_idle", 32'(busy), 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: no done for 50 WAIT_DONE cycles
    req_data  = 32'h0000_6601;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    for (int i = 0; i < 49; i++) tick();
    chk("t_busy_pre", 32'(busy), 1);
    chk("t_err_pre", 32'(timeout_err), 0);
    tick();
    chk("t_busy_post", 32'(busy), 0);
    chk("t_err_post", 32'(timeout_err), 1);
    req_valid = 4'b0011;
    #1;
    chk("t_ready_next", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    chk("t_grant_next", 32'(grant_id), 1);
    chk("t_data_next", 32'(uart_data), 32'h66);
    tick();
    pulse_done();
    chk("t_err_sticky", 32'(timeout_err), 1);
`else
    // Without the watchdog WAIT_DONE holds indefinitely
    req_data  = 32'h0000_0001;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    for (int i = 0; i < 80; i++) tick();
    chk("n_busy_hold", 32'(busy), 1);
    chk("n_err_zero", 32'(timeout_err), 0);
    pulse_done();
    chk("n_idle", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (start / data_in / tx_done interface) between NUM_REQ byte requesters using round-robin arbitration.
- Sequences exactly one byte per grant: accept, pulse start, hold data, wait for tx_done, then re-arbitrate.
- Sits between on-chip byte producers (debug console, status reporter, loopback self-test) and the UART TX core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width
- TIMEOUT_CYCLES, 200000, maximum cycles to wait for uart_tx_done (used only with the optional watchdog)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  per-requester accept, combinational, one-hot or zero
- uart_start  output  1  one-cycle start pulse to the UART TX
- uart_data  output  DATA_W  byte to the UART TX, registered, stable from START until tx_done
- uart_tx_done  input  1  one-cycle completion pulse from the UART TX
- grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  sticky watchdog flag

Behaviour:
- States: IDLE, START, WAIT_DONE.
- Reset values: state=IDLE, uart_start=0, uart_data=0, grant_id=0, busy=0, timeout_err=0, last_grant=NUM_REQ-1. After reset, requester 0 has first priority.
- IDLE:
  - Search order is last_grant+1, last_grant+2, ... with modulo-NUM_REQ wrap. The first asserted req_valid wins.
  - req_ready[winner]=1 combinationally in this cycle. The transfer occurs on valid&ready.
  - At the clock edge: uart_data<=req_data[winner], grant_id<=winner, last_grant<=winner, state->START.
  - With no valid requests, the block stays in IDLE and all req_ready are 0.
- START:
  - uart_start=1 for exactly this one cycle; state->WAIT_DONE.
  - uart_tx_done is ignored in this state.
- WAIT_DONE:
  - On uart_tx_done=1, state->IDLE.
  - The next grant can occur in the following cycle, giving a minimum of 3 cycles per byte plus UART time.
- req_ready is 0 in every state except IDLE.
- A requester that drops req_valid before it is granted loses nothing; there is no queueing inside the block.
- uart_tx_done seen in IDLE is ignored.
- Simultaneous requests: exactly one grant per arbitration. A requester that has just been served drops to lowest priority.
- Reset mid-transaction: the in-flight byte is abandoned. All state returns to reset values at the next edge, and uart_start is never left asserted.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - If the counter reaches TIMEOUT_CYCLES without uart_tx_done, timeout_err<=1 (sticky until rst), the byte is dropped and state->IDLE.
  - last_grant is still updated, so the failing requester does not starve the others.
- When undefined: WAIT_DONE waits indefinitely, timeout_err is tied to 0, and no counter is built.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - the state encoding constants (IDLE=2'd0, START=2'd1, WAIT_DONE=2'd2)
  - the grant-index width function
  - a default TIMEOUT_CYCLES constant
- Sub-module rr_pick: purely combinational. Inputs are the request vector and last_grant; outputs are a one-hot grant and its index. The FSM and datapath stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid[0]=1 with 0x55 -> req_ready[0] high 1 cycle; uart_start pulses the next cycle with uart_data=0x55 and grant_id=0; busy falls 1 cycle after uart_tx_done.
- Contention: req0=0x55 and req2=0xAA asserted together after reset -> 0x55 sent first, then 0xAA; req_ready[2] stays 0 until the first uart_tx_done.
- Fairness: all four requesters held valid with bytes 0x10..0x13 -> grant order 0,1,2,3,0,1; no requester is granted twice before all others.
- Wrap-around: last_grant=3, only req1 valid -> req1 granted; then req3 and req1 valid -> req3 granted first.
- Reset mid-WAIT_DONE: rst asserted 5 cycles after uart_start -> next cycle busy=0, uart_start=0, grant_id=0; the next request from req0 is served normally.
- Watchdog (macro on, TIMEOUT_CYCLES=50): uart_tx_done never asserted -> timeout_err=1 after 50 WAIT_DONE cycles, state returns to IDLE, and the next requester is served.
